zero_cnt_seq: RTL



---
 rtl/zero_cnt_pkg.sv | 16 +
 rtl/chunk_lzc.sv | 31 +++
 rtl/zero_cnt_seq.sv | 128 ++++++++++++
 3 files changed

// File: rtl/zero_cnt_pkg.sv
// Shared types and encodings for the sequential zero/one run-length counter.
package zero_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic DIR_LEAD  = 1'b1;
    localparam logic DIR_TRAIL = 1'b0;

    localparam logic CNT_ZEROS = 1'b0;
    localparam logic CNT_ONES  = 1'b1;

endpackage

// File: rtl/chunk_lzc.sv
// Combinational leading-zero count of a W-bit chunk, scanned from the MSB.
module chunk_lzc #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0]             chunk,
    output logic [$clog2(W+1)-1:0]   clz,
    output logic                     all_zero
);

    localparam int unsigned CW = $clog2(W + 1);

    // seen[k] is set once any bit among the top k+1 positions is one.
    logic [W-1:0] seen;

    assign seen[0] = chunk[W-1];

    for (genvar k = 1; k < W; k++) begin : g_scan
        assign seen[k] = seen[k-1] | chunk[W-1-k];
    end

    // ~seen is a thermometer code, so its population count is the zero run length.
    always_comb begin
        clz = '0;
        for (int k = 0; k < W; k++) begin
            clz = clz + CW'(~seen[k]);
        end
    end

    assign all_zero = ~seen[W-1];

endmodule

// File: rtl/zero_cnt_seq.sv
// Sequential leading/trailing zero-or-one counter, CHUNK_WIDTH bits per cycle with early exit.
module zero_cnt_seq
    import zero_cnt_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHUNK_WIDTH = 8,
    parameter int unsigned CNT_WIDTH   = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_dir,
    input  logic                  in_cnt_ones,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  out_cnt,
    output logic                  out_all
);

    localparam int unsigned NCHUNK = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CLZ_W  = $clog2(CHUNK_WIDTH + 1);

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_bad_chunk
        $error("DATA_WIDTH must be an integer multiple of CHUNK_WIDTH");
    end

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  all_q, all_d;

    logic [DATA_WIDTH-1:0] pre_data;
    logic [CLZ_W-1:0]      chunk_clz;
    logic                  chunk_all_zero;
    logic [CNT_WIDTH-1:0]  scan_sum;
    logic                  last_chunk;

    // Normalise every request to "count leading zeros from the MSB".
    always_comb begin
        pre_data = in_data;
        if (in_dir == DIR_TRAIL) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                pre_data[i] = in_data[DATA_WIDTH-1-i];
            end
        end
        if (in_cnt_ones == CNT_ONES) begin
            pre_data = ~pre_data;
        end
    end

    chunk_lzc #(
        .W (CHUNK_WIDTH)
    ) u_chunk_lzc (
        .chunk    (shreg_q[DATA_WIDTH-1 -: CHUNK_WIDTH]),
        .clz      (chunk_clz),
        .all_zero (chunk_all_zero)
    );

    assign scan_sum   = acc_q + CNT_WIDTH'(chunk_clz);
    assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        all_d   = all_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d = pre_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (chunk_all_zero && !last_chunk) begin
                    acc_d   = acc_q + CNT_WIDTH'(CHUNK_WIDTH);
                    shreg_d = shreg_q << CHUNK_WIDTH;
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    acc_d   = scan_sum;
                    cnt_d   = scan_sum;
                    all_d   = (scan_sum == CNT_WIDTH'(DATA_WIDTH));
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            all_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            all_q   <= all_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_cnt   = cnt_q;
    assign out_all   = all_q;

endmodule
